// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and
// nibble-count helpers.
package nsa_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int NIBBLES       = DEFAULT_WIDTH / 4;
    localparam int CNT_W         = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } nsa_state_e;

    function automatic int nibbles(input int width);
        return width / 4;
    endfunction

    // Counter width for an arbitrary operand width; never narrower than 1 bit.
    function automatic int cnt_width(input int width);
        return (width / 4 > 1) ? $clog2(width / 4) : 1;
    endfunction

endpackage

// File: rtl/claAdder4b.sv
// 4-bit carry-lookahead adder, purely combinational.
module claAdder4b (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = ci_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s_o  = p ^ c[3:0];
    assign co_o = c[4];

endmodule

// File: rtl/nibble_serial_add16.sv
// Multi-cycle add/subtract: one claAdder4b stepped across the operands a nibble
// per clock, with a start/busy/done handshake for the control unit.
module nibble_serial_add16
    import nsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             ovf,
    output logic             zero,
    output nsa_state_e       dbg_state_o
);

    localparam int NIB = nibbles(WIDTH);
    localparam int KW  = cnt_width(WIDTH);

    // Handshake: start is honoured only in IDLE and its operands are captured
    // on that edge; busy covers the nibble cycles; done is a single-cycle pulse
    // from which r/co/ovf/zero are valid and held until the next done.

    nsa_state_e       state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] r_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             co_q;
    logic             ovf_q;
    logic             zero_q;

    logic [KW+1:0]    base;
    logic [3:0]       nib_s;
    logic             nib_co;
    logic             last_nib;

    assign base     = {k_q, 2'b00};
    assign last_nib = (k_q == KW'(NIB - 1));

    claAdder4b u_cla (
        .a_i  (opa_q[base +: 4]),
        .b_i  (opb_q[base +: 4]),
        .ci_i (carry_q),
        .s_o  (nib_s),
        .co_o (nib_co)
    );

    always_comb begin
        acc_d            = acc_q;
        acc_d[base +: 4] = nib_s;
    end

    // Results are registered from acc_d on the last nibble edge so they are
    // already valid in the DONE cycle that raises the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : ci;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= nib_co;
                    k_q     <= k_q + KW'(1);
                    if (last_nib) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        r_q     <= acc_d;
                        co_q    <= nib_co;
                        ovf_q   <= (opa_q[WIDTH-1] == opb_q[WIDTH-1])
                                && (acc_d[WIDTH-1] != opa_q[WIDTH-1]);
                        zero_q  <= (acc_d == '0);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign r           = r_q;
    assign co          = co_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nibble_serial_add16.sv
// Directed and random checks of nibble_serial_add16 against a signed/unsigned
// arithmetic model held in an expected-result queue.
module tb_nibble_serial_add16;
    import nsa_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         ci = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic         co;
    logic         ovf;
    logic         zero;
    nsa_state_e   dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;

    // {r, co, ovf, zero}
    logic [W+2:0] exp_q[$];

    nibble_serial_add16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sub         (sub),
        .a           (a),
        .b           (b),
        .ci          (ci),
        .busy        (busy),
        .done        (done),
        .r           (r),
        .co          (co),
        .ovf         (ovf),
        .zero        (zero),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input logic [W-1:0] ia, input logic [W-1:0] ib,
                               input logic ici, input logic isub);
        logic [W:0] sum;
        int sa;
        int sb;
        int sr;
        logic ov;
        sa = $signed(ia);
        sb = $signed(ib);
        if (isub) begin
            sum = {1'b0, ia} + {1'b0, ~ib} + 1;
            sr  = sa - sb;
        end else begin
            sum = {1'b0, ia} + {1'b0, ib} + ici;
            sr  = sa + sb + int'(ici);
        end
        ov = (sr > 32767) || (sr < -32768);
        exp_q.push_back({sum[W-1:0], sum[W], ov, (sum[W-1:0] == '0)});
    endtask

    task automatic begin_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ici, input logic isub);
        a = ia;
        b = ib;
        ci = ici;
        sub = isub;
        start = 1'b1;
        push_expect(ia, ib, ici, isub);
        t0 = cyc;
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        ci = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic await_done(input string tag);
        logic [W+2:0] e;
        logic [W-1:0] r_hold;
        bit seen;
        r_hold = r;
        seen = 0;
        for (int n = 0; n < 12 && !seen; n++) begin
            chk({tag, "_busy_and_done"}, 32'(busy & done), 0);
            if (done) begin
                seen = 1;
                chk({tag, "_latency"}, cyc - t0, 5);
                chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
                e = exp_q.pop_front();
                chk({tag, "_r"}, 32'(r), 32'(e[W+2:3]));
                chk({tag, "_co"}, 32'(co), 32'(e[2]));
                chk({tag, "_ovf"}, 32'(ovf), 32'(e[1]));
                chk({tag, "_zero"}, 32'(zero), 32'(e[0]));
            end else begin
                chk({tag, "_busy"}, 32'(busy), 1);
                chk({tag, "_r_stable"}, 32'(r), 32'(r_hold));
                step();
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        step();
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_r", 32'(r), 0);
        chk("rst_flags", {29'b0, co, ovf, zero}, 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();

        // Add with carry-in toggled
        begin_op(16'h000A, 16'h0001, 1'b0, 1'b0);
        await_done("add_ci0");
        begin_op(16'h000A, 16'h0001, 1'b1, 1'b0);
        await_done("add_ci1");

        // Carry ripples through every nibble
        begin_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        await_done("carry_chain");

        // Signed overflow and borrow; ci must be ignored for sub
        begin_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        await_done("ovf_add");
        begin_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        await_done("borrow_sub");
        begin_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        await_done("ovf_sub");
        begin_op(16'h1234, 16'h1234, 1'b0, 1'b1);
        await_done("sub_zero");

        // start and operand changes while busy and in DONE are ignored;
        // the held start is only taken once the unit is back in IDLE
        begin_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        step();
        a = 16'h0F0F;
        b = 16'h0101;
        ci = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        push_expect(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        await_done("busy_start_first");
        t0 = cyc;
        step();
        start = 1'b0;
        await_done("busy_start_second");

        // Random back-to-back operations
        for (int i = 0; i < 8; i++) begin
            begin_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            await_done("random");
        end

        // Reset mid-operation discards the operation and clears outputs
        begin_op(16'h4321, 16'h0101, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_r", 32'(r), 0);
        chk("midrst_flags", {29'b0, co, ovf, zero}, 0);
        chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        for (int n = 0; n < 10; n++) begin
            step();
            chk("midrst_no_done", 32'(done), 0);
            chk("midrst_no_busy", 32'(busy), 0);
        end

        // Unit recovers after the aborted operation
        begin_op(16'h00F0, 16'h0F10, 1'b0, 1'b0);
        await_done("post_reset");

        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
